stack_reverser: RTL and testbench

Stream-reversal front end that drives an external LIFO stack through its push/pop port. Accepts an input word stream with valid/ready handshake and pushes each word into the stack. On frame end or stack capacity, it pops the stack and emits the words in reverse order on an output valid/ready stream. It is the initiator side of the stack interface and sits between a producer and a consumer that require last-in-first-out frame order.

---
 rtl/stack_reverser.sv | 119 +++++++++++
 tb/tb_stack_reverser.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_reverser.sv
// Frame reverser that drives an external LIFO through its push/pop port.
// Optional protocol checker on err is enabled by defining STACK_REVERSER_CHECK_EN.
module stack_reverser #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout,
  input  logic             stk_full,
  input  logic             stk_empty,
  output logic             busy,
  output logic             err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] OneC   = CW'(1);

  typedef enum logic [1:0] {StFill, StPop, StEmit} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          seg_last_q, seg_last_d;
  logic          accept, out_fire;

  assign accept   = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StFill;
      count_q    <= '0;
      seg_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      seg_last_q <= seg_last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    seg_last_d = seg_last_q;
    unique case (state_q)
      StFill: begin
        if (accept) begin
          count_d = count_q + OneC;
          if (in_last) begin
            seg_last_d = 1'b1;
            state_d    = StPop;
          end else if (count_q + OneC == DepthC) begin
            seg_last_d = 1'b0;
            state_d    = StPop;
          end
        end
      end
      StPop: state_d = StEmit;
      StEmit: begin
        if (out_fire) begin
          count_d = count_q - OneC;
          if (count_q == OneC) begin
            state_d    = StFill;
            seg_last_d = 1'b0;
          end else begin
            state_d = StPop;
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  // Every output is gated by rstn so the block is fully silent while held in reset.
  always_comb begin
    in_ready  = rstn & (state_q == StFill) & (count_q < DepthC);
    stk_push  = in_ready & in_valid;
    stk_din   = stk_push ? in_data : '0;
    stk_pop   = rstn & (state_q == StPop);
    out_valid = rstn & (state_q == StEmit);
    out_data  = out_valid ? stk_dout : '0;
    out_last  = out_valid & seg_last_q & (count_q == OneC);
    busy      = rstn & ((count_q != '0) | (state_q != StFill));
  end

`ifdef STACK_REVERSER_CHECK_EN
  logic err_q, chk_fail;

  // In EMIT the stack already holds one word fewer than count, so the
  // full-vs-count rule is only meaningful in FILL and POP.
  assign chk_fail = ((state_q == StFill) & stk_full & (count_q < DepthC)) |
                    ((state_q == StPop) & stk_empty) |
                    ((state_q != StEmit) & ~stk_full & (count_q == DepthC));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_q <= 1'b0;
    else       err_q <= err_q | chk_fail;
  end

  assign err = err_q;
`else
  logic unused_chk;
  assign unused_chk = stk_full ^ stk_empty;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_stack_reverser.sv
// Self-checking bench for stack_reverser with a behavioural LIFO attached.
module tb_stack_reverser;
  localparam int W = 4;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic [W-1:0] out_data;
  logic         out_valid, out_last;
  logic         out_ready = 1'b0;
  logic         stk_push, stk_pop;
  logic [W-1:0] stk_din, stk_dout;
  logic         stk_full, stk_empty, busy, err;

  int checks = 0, errors = 0;
  int overlap = 0, both = 0;
  bit rand_rdy = 1'b0;
  logic force_empty = 1'b0;

  logic [W-1:0] exp_d[$], got_d[$];
  logic         exp_l[$], got_l[$];

  always #5 clk = ~clk;

  stack_reverser #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
    .stk_dout(stk_dout), .stk_full(stk_full), .stk_empty(stk_empty), .busy(busy), .err(err)
  );

  // Behavioural LIFO sharing rstn with the DUT.
  logic [W-1:0] mem [D];
  int sp;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sp <= 0;
      stk_dout <= '0;
    end else if (stk_push && sp < D) begin
      mem[sp] <= stk_din;
      sp <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      stk_dout <= mem[sp-1];
      sp <= sp - 1;
    end
  end
  assign stk_full  = (sp == D);
  assign stk_empty = (sp == 0) || force_empty;

  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_l.push_back(out_last);
    end
    if (out_valid && in_ready) overlap++;
    if (stk_push && stk_pop) both++;
  end

  always @(posedge clk) begin
    #2;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  // Reference: split frame into DEPTH chunks, reverse each; last flag on final word only.
  task automatic model_frame(input logic [W-1:0] f[$]);
    for (int s = 0; s < f.size(); s += D) begin
      int e = (s + D < f.size()) ? s + D : f.size();
      for (int i = e - 1; i >= s; i--) begin
        exp_d.push_back(f[i]);
        exp_l.push_back(e == f.size() && i == s);
      end
    end
  endtask

  task automatic send_frame(input logic [W-1:0] f[$]);
    for (int i = 0; i < f.size(); i++) begin
      bit took = 1'b0;
      int t = 0;
      in_valid = 1'b1;
      in_data  = f[i];
      in_last  = (i == f.size() - 1);
      while (!took && t < 200) begin
        @(negedge clk);
        took = in_ready;
        @(posedge clk);
        #1;
        t++;
      end
      if (!took) begin
        checks++; errors++;
        $display("FAIL send_frame word %0d: in_ready stayed 0, want 1", i);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic check_outputs(input string name, input int budget);
    int t = 0;
    int n;
    while (got_d.size() < exp_d.size() && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    checks++;
    if (got_d.size() != exp_d.size()) begin
      errors++;
      $display("FAIL %s count: got %0d words, want %0d", name, got_d.size(), exp_d.size());
    end
    n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL %s word %0d: got data=%h last=%b, want data=%h last=%b",
                 name, i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b1; in_data = 4'h5; in_last = 1'b1; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_last, out_data, stk_push, stk_pop, stk_din, busy, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b ov=%b ol=%b od=%h push=%b pop=%b din=%h busy=%b err=%b, want all 0",
               in_ready, out_valid, out_last, out_data, stk_push, stk_pop, stk_din, busy, err);
    end
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got in_ready=%b busy=%b out_valid=%b, want 1 0 0",
               in_ready, busy, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_short_frame();
    logic [W-1:0] f[$];
    f = '{4'h3, 4'h7, 4'hA};
    out_ready = 1'b1;
    model_frame(f);
    send_frame(f);
    @(negedge clk);
    checks++;
    if (stk_pop !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL short_pop_cycle: got pop=%b ov=%b rdy=%b, want 1 0 0", stk_pop, out_valid, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'hA) begin
      errors++;
      $display("FAIL short_first_out: got ov=%b data=%h, want 1 a", out_valid, out_data);
    end
    check_outputs("short", 50);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL short_after: got in_ready=%b busy=%b, want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_long_frame();
    logic [W-1:0] f[$];
    for (int i = 1; i <= 10; i++) f.push_back(W'(i));
    out_ready = 1'b1;
    model_frame(f);
    send_frame(f);
    check_outputs("long", 100);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] f[$];
    int t = 0;
    f = '{4'h5, 4'h6};
    out_ready = 1'b0;
    model_frame(f);
    send_frame(f);
    while (t < 10) begin
      @(negedge clk);
      if (out_valid) break;
      t++;
    end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 4'h6 || out_last !== 1'b0 || stk_pop !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold %0d: got ov=%b data=%h last=%b pop=%b, want 1 6 0 0",
                 k, out_valid, out_data, out_last, stk_pop);
      end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    check_outputs("backpressure", 50);
  endtask

  task automatic test_reset_mid_drain();
    logic [W-1:0] f[$];
    int t = 0;
    for (int i = 0; i < 4; i++) f.push_back(W'($urandom));
    out_ready = 1'b1;
    exp_d.push_back(f[3]);
    exp_l.push_back(1'b0);
    send_frame(f);
    while (got_d.size() < 1 && t < 20) begin
      @(posedge clk); #1; t++;
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || stk_pop !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_drain_reset: got ov=%b busy=%b pop=%b rdy=%b, want 0 0 0 0",
               out_valid, busy, stk_pop, in_ready);
    end
    check_outputs("mid_drain_first", 0);
    @(posedge clk); #1 rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    f = '{4'h2, 4'hC};
    model_frame(f);
    send_frame(f);
    check_outputs("after_reset", 50);
  endtask

  task automatic test_random();
    rand_rdy = 1'b1;
    for (int fr = 0; fr < 8; fr++) begin
      logic [W-1:0] f[$];
      int len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) f.push_back(W'($urandom));
      model_frame(f);
      send_frame(f);
      check_outputs($sformatf("random%0d", fr), 400);
    end
    rand_rdy = 1'b0;
    @(posedge clk); #3 out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_checker();
`ifdef STACK_REVERSER_CHECK_EN
    logic [W-1:0] f[$];
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clean: got %b, want 0", err);
    end
    f = '{4'h9};
    out_ready = 1'b1;
    model_frame(f);
    send_frame(f);
    force_empty = 1'b1;
    @(posedge clk); #1 force_empty = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_set: got %b, want 1", err);
    end
    check_outputs("checker_frame", 50);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b, want 1", err);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_reset: got %b, want 0", err);
    end
    @(posedge clk); #1 rstn = 1'b1;
`else
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_tied: got %b, want 0", err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_short_frame();
    test_long_frame();
    test_backpressure();
    test_reset_mid_drain();
    test_random();
    test_checker();
    checks++;
    if (overlap != 0 || both != 0) begin
      errors++;
      $display("FAIL protocol: got ready_during_emit=%0d push_with_pop=%0d, want 0 0", overlap, both);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
